// File: rtl/acc_ctrl16_if.sv
// Handshake and adder-side bus of acc_ctrl16: command in, result out, and
// the register-driven connection to the external 16-bit adder/subtractor.
interface acc_ctrl16_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  cmd;
  logic [15:0] operand;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_op;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] acc;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;

  modport slave (
    input  in_valid, cmd, operand, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_op, out_valid, acc,
           flag_z, flag_n, flag_c, flag_v
  );

  modport master (
    output in_valid, cmd, operand, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_op, out_valid, acc,
           flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/acc_ctrl16.sv
// Control stage around an external 16-bit adder/subtractor: accepts a command,
// runs it through the adder for one cycle and holds the accumulator and flags.
module acc_ctrl16 (
  input logic         clk,
  input logic         rst,
  acc_ctrl16_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] CMD_CLR  = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_ADD  = 2'b10;
  localparam logic [1:0] CMD_SUB  = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [15:0] opnd_q, opnd_d;
  logic [15:0] acc_q, acc_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        c_q, c_d;
  logic        v_q, v_d;

  // Next-state, command capture and accumulator/flag update
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_EXEC;
          cmd_d   = bus.cmd;
          opnd_d  = bus.operand;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        case (cmd_q)
          CMD_CLR: begin
            acc_d = 16'h0000;
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
          CMD_LOAD: begin
            acc_d = opnd_q;
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
          CMD_ADD: begin
            acc_d = bus.add_sum;
            c_d   = bus.add_cout;
            v_d   = (acc_q[15] == opnd_q[15]) && (bus.add_sum[15] != acc_q[15]);
          end
          CMD_SUB: begin
            // adder cout for subtraction is the inverted borrow
            acc_d = bus.add_sum;
            c_d   = bus.add_cout;
            v_d   = (acc_q[15] != opnd_q[15]) && (bus.add_sum[15] != acc_q[15]);
          end
          default: begin
            acc_d = 16'h0000;
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
        endcase
        z_d = (acc_d == 16'h0000);
        n_d = acc_d[15];
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, command, operand, accumulator and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_CLR;
      opnd_q  <= 16'h0000;
      acc_q   <= 16'h0000;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.add_a     = acc_q;
  assign bus.add_b     = opnd_q;
  assign bus.add_op    = (cmd_q == CMD_SUB);
  assign bus.acc       = acc_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;

endmodule

// File: tb/tb_acc_ctrl16.sv
// Bench for acc_ctrl16: directed plan vectors plus random commands checked
// against an arithmetic model of the accumulator; includes the adder itself.
module tb_acc_ctrl16;
  logic clk;
  logic rst;
  acc_ctrl16_if bus ();

  acc_ctrl16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational adder/subtractor the block drives
  logic [16:0] adder_res;
  assign adder_res    = bus.add_op ? ({1'b0, bus.add_a} + {1'b0, ~bus.add_b} + 17'd1)
                                   : ({1'b0, bus.add_a} + {1'b0, bus.add_b});
  assign bus.add_sum  = adder_res[15:0];
  assign bus.add_cout = adder_res[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [15:0] m_acc;
  logic        m_z, m_n, m_c, m_v;

  function automatic int sval(input logic [15:0] x);
    return x[15] ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic model_apply(input logic [1:0] c, input logic [15:0] op);
    int s, sv;
    case (c)
      2'b00: begin m_acc = 16'h0000; m_c = 1'b0; m_v = 1'b0; end
      2'b01: begin m_acc = op; m_c = 1'b0; m_v = 1'b0; end
      2'b10: begin
        s     = int'(m_acc) + int'(op);
        sv    = sval(m_acc) + sval(op);
        m_c   = (s > 65535);
        m_v   = (sv > 32767) || (sv < -32768);
        m_acc = 16'(s % 65536);
      end
      default: begin
        s     = int'(m_acc) - int'(op);
        sv    = sval(m_acc) - sval(op);
        m_c   = (int'(m_acc) >= int'(op));
        m_v   = (sv > 32767) || (sv < -32768);
        m_acc = 16'((s + 65536) % 65536);
      end
    endcase
    m_z = (m_acc == 16'h0000);
    m_n = m_acc[15];
  endtask

  // Drive one command from IDLE to DONE; leaves the result pending
  task automatic run_cmd(input logic [1:0] c, input logic [15:0] op);
    logic [19:0] got, exp;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_in_ready: got %0b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.cmd      = c;
    bus.operand  = op;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.add_a, bus.add_op} !== {1'b0, 1'b0, m_acc, (c == 2'b11)}) begin
      n_err++;
      $display("FAIL exec_drive: got rdy=%0b vld=%0b a=%h op=%0b want rdy=0 vld=0 a=%h op=%0b",
               bus.in_ready, bus.out_valid, bus.add_a, bus.add_op, m_acc, (c == 2'b11));
    end
    if (c != 2'b00) begin
      n_cmp++;
      if (bus.add_b !== op) begin
        n_err++;
        $display("FAIL exec_add_b: got %h want %h", bus.add_b, op);
      end
    end
    bus.in_valid = 1'b0;
    model_apply(c, op);
    @(posedge clk); #1;
    got = {bus.acc, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
    exp = {m_acc, m_z, m_n, m_c, m_v};
    n_cmp++;
    if (bus.out_valid !== 1'b1 || got !== exp) begin
      n_err++;
      $display("FAIL result cmd=%0d op=%h: got vld=%0b acc=%h znc v=%b want vld=1 acc=%h znc v=%b",
               c, op, bus.out_valid, got[19:4], got[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  task automatic finish_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL out_handshake: got vld=%0b rdy=%0b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.acc, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v,
         bus.add_a, bus.add_b, bus.add_op} !== {1'b1, 1'b0, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b acc=%h f=%b a=%h b=%h op=%0b want rdy=1 vld=0 all zero",
               bus.in_ready, bus.out_valid, bus.acc,
               {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, bus.add_a, bus.add_b, bus.add_op);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  tc [10] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00};
    logic [15:0] to [10] = '{16'h0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0001,
                             16'h0005, 16'h0005, 16'hFFFF, 16'h0001, 16'h0000};
    logic [15:0] ea [10] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF,
                             16'h0005, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    logic [3:0]  ef [10] = '{4'b1000, 4'b0000, 4'b0101, 4'b1000, 4'b0100,
                             4'b0000, 4'b1010, 4'b0100, 4'b1010, 4'b1000};
    for (int i = 0; i < 10; i++) begin
      run_cmd(tc[i], to[i]);
      n_cmp++;
      if ({bus.acc, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== {ea[i], ef[i]}) begin
        n_err++;
        $display("FAIL plan_%0d: got acc=%h znc v=%b want acc=%h znc v=%b", i, bus.acc,
                 {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, ea[i], ef[i]);
      end
      finish_out();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    run_cmd(2'b01, 16'h1357);
    held = bus.acc;
    bus.in_valid = 1'b1;
    bus.cmd      = 2'b10;
    bus.operand  = 16'h0101;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.acc} !== {1'b1, 1'b0, held}) begin
        n_err++;
        $display("FAIL backpressure_%0d: got vld=%0b rdy=%0b acc=%h want vld=1 rdy=0 acc=%h",
                 i, bus.out_valid, bus.in_ready, bus.acc, held);
      end
    end
    finish_out();
    run_cmd(2'b10, 16'h0101);
    finish_out();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_cmd(2'($urandom_range(3, 1)), 16'($urandom));
      finish_out();
    end
  endtask

  task automatic test_random();
    logic [19:0] held;
    int d;
    for (int i = 0; i < 80; i++) begin
      run_cmd(2'($urandom_range(3, 0)), 16'($urandom));
      held = {bus.acc, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
      d = $urandom_range(2, 0);
      for (int k = 0; k < d; k++) begin
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.out_valid, bus.acc, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== {1'b1, held}) begin
          n_err++;
          $display("FAIL random_hold_%0d: got vld=%0b acc=%h want vld=1 acc=%h", i, bus.out_valid, bus.acc, held[19:4]);
        end
      end
      finish_out();
    end
  endtask

  task automatic test_reset_mid_exec();
    run_cmd(2'b01, 16'h0001);
    finish_out();
    bus.in_valid = 1'b1;
    bus.cmd      = 2'b10;
    bus.operand  = 16'h1234;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.acc, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.out_valid, bus.in_ready, bus.add_op}
        !== {16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_exec: got acc=%h f=%b vld=%0b rdy=%0b op=%0b want acc=0000 f=0000 vld=0 rdy=1 op=0",
               bus.acc, {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, bus.out_valid, bus.in_ready, bus.add_op);
    end
    rst = 1'b0;
    m_acc = 16'h0000; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.out_valid, bus.acc} !== {1'b0, 16'h0000}) begin
        n_err++;
        $display("FAIL no_result_after_reset_%0d: got vld=%0b acc=%h want vld=0 acc=0000", i, bus.out_valid, bus.acc);
      end
    end
    bus.out_ready = 1'b0;
    run_cmd(2'b10, 16'h00FF);
    finish_out();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_acc = 16'h0000; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.cmd       = 2'b00;
    bus.operand   = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/acc_ctrl16.md
# acc_ctrl16

Sequential control stage wrapped around the combinational 16-bit adder/subtractor. It accepts a command and operand through a valid/ready handshake and drives the adder's `a`, `b` and `op` inputs from registers. It captures the adder's `sum` and `cout` into a 16-bit accumulator with status flags, then presents the result downstream through a second valid/ready handshake. The adder is instantiated beside this block, not inside it, and must settle within one clock period.

## Interface
Parameters:
- None. The width is fixed at 16 bits to match the adder.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  command/operand valid
- `in_ready`  out  1  block can accept a command
- `cmd`  in  2  command: 00 CLR, 01 LOAD, 10 ADD, 11 SUB
- `operand`  in  16  operand for LOAD/ADD/SUB; ignored for CLR
- `add_a`  out  16  to adder `a`; always equals `acc`
- `add_b`  out  16  to adder `b`; always equals `opnd_r`
- `add_op`  out  1  to adder `op`; 1 when `cmd_r` is SUB, else 0
- `add_sum`  in  16  from adder `sum`
- `add_cout`  in  1  from adder `cout`
- `out_valid`  out  1  result/flags valid
- `out_ready`  in  1  downstream accepts the result
- `acc`  out  16  accumulator value
- `flag_z`  out  1  `acc` == 0
- `flag_n`  out  1  `acc[15]`
- `flag_c`  out  1  carry; for SUB, 1 means no borrow (a >= b unsigned)
- `flag_v`  out  1  signed overflow

## Operation
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid` is high, register `cmd_r` <= `cmd` and `opnd_r` <= `operand` (`operand` is don't-care for CLR), then go to EXEC.
  - EXEC: drive the adder from registers and update the accumulator on the edge leaving EXEC:
    - CLR: `acc` <= 0, C=0, V=0.
    - LOAD: `acc` <= `opnd_r`, C=0, V=0.
    - ADD: `acc` <= `add_sum`, C=`add_cout`, V=(`a[15]`==`b[15]`) && (`sum[15]`!=`a[15]`).
    - SUB: `acc` <= `add_sum`, C=`add_cout`, V=(`a[15]`!=`b[15]`) && (`sum[15]`!=`a[15]`).
    - Z and N are always computed from the new `acc` value.
    - Then go to DONE.
  - DONE: `out_valid`=1. When `out_ready` is high, go to IDLE.
- `in_ready`=0 in EXEC and DONE. A command presented then is not consumed; upstream must hold `in_valid`, `cmd` and `operand` stable until `in_ready` is high.
- `acc` and the flags are registered. They change only on the EXEC->DONE edge and hold their value in all other states, so the accumulator persists across commands.
- `add_a`/`add_b`/`add_op` are continuous functions of the registers. They are meaningful only in EXEC; in other states they are don't-care for the adder but still equal `acc`/`opnd_r`/(`cmd_r`==SUB).
- Arithmetic is modulo 2^16: wrap-around produces no exception, only the C/V flags.
- Reset (any state, including mid-EXEC): state=IDLE, `acc`=0, `opnd_r`=0, `cmd_r`=00, all flags 0, `out_valid`=0, `in_ready`=1, `add_op`=0. An in-flight command is discarded.

## Timing
- Accept at edge E0 (IDLE, `in_valid`=1). EXEC occupies the cycle after E0. `acc`/flags update at E1, and `out_valid` rises after E1.
- Latency from accepting a command to `out_valid`: 2 edges.
- Earliest next accept: `out_ready` sampled high at E1+1 returns the FSM to IDLE, and the next accept is at E1+2. Peak throughput is one command per 3 cycles.
- Simultaneous `in_valid` and `out_valid`: the input waits; the output handshake completes first.
- `out_ready` held low: `out_valid`, `acc` and the flags stay constant indefinitely.
- Reset release: the first accept can occur at the first rising edge with `rst`=0.

## Test plan
- Reset, then CLR -> `acc`=0x0000, Z=1, N=0, C=0, V=0, `out_valid` rising 2 edges after accept.
- LOAD 0x7FFF, then ADD 0x0001 -> `acc`=0x8000, N=1, V=1, C=0, Z=0. Check `add_a`=0x7FFF, `add_b`=0x0001, `add_op`=0 during EXEC.
- LOAD 0x0000, then SUB 0x0001 -> `acc`=0xFFFF, C=0 (borrow), N=1, V=0. Then LOAD 0x0005, SUB 0x0005 -> `acc`=0x0000, Z=1, C=1, V=0; `add_op`=1 in EXEC.
- LOAD 0xFFFF, then ADD 0x0001 -> `acc`=0x0000, C=1, Z=1, V=0 (unsigned wrap).
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 held -> `out_valid` and `acc` stable, `in_ready`=0 throughout. After release, the pending command is accepted at the second edge.
- Assert `rst` during EXEC of ADD 0x1234 on `acc`=0x0001 -> immediately `acc`=0, flags 0, `out_valid`=0, `in_ready`=1, and no result is emitted after release.
